// File: rtl/display_cell_plotter_if.sv
// Request/pixel bundle between a draw requester and display_cell_plotter.
// The requester owns the request fields; the plotter owns status and the pixel stream.
interface display_cell_plotter_if #(
  parameter int BW = 1
);
  logic          req;
  logic          mode;
  logic [BW-1:0] board;
  logic [3:0]    cellX;
  logic [3:0]    cellY;
  logic [2:0]    colourIn;
  logic          busy;
  logic          done;
  logic          err;
  logic          plotEn;
  logic [7:0]    posX;
  logic [6:0]    posY;
  logic [2:0]    colourOut;

  // Handshake: req is a level sampled only while the plotter is idle. Exactly one
  // of {accept -> busy next cycle, reject -> err pulse} follows each sampled req;
  // req seen while busy or finishing is dropped, never queued.
  modport master (
    output req, mode, board, cellX, cellY, colourIn,
    input  busy, done, err, plotEn, posX, posY, colourOut
  );
  modport slave (
    input  req, mode, board, cellX, cellY, colourIn,
    output busy, done, err, plotEn, posX, posY, colourOut
  );
endinterface

// File: rtl/display_cell_plotter.sv
// Plots one CELLxCELL cell, or every cell of a GRIDxGRID board, one pixel per cycle.
// Pixel coordinates and colour are registered and held between plots.
module display_cell_plotter #(
  parameter int GRID       = 10,
  parameter int CELL       = 4,
  parameter int PITCH      = 5,
  parameter int NUM_BOARDS = 2,
  parameter int X_BASE     = 26,
  parameter int X_STRIDE   = 64,
  parameter int Y_BASE     = 36
) (
  input  logic                   clk,
  input  logic                   Reset,
  display_cell_plotter_if.slave  bus,
  output logic [1:0]             state_dbg
);
  localparam int BW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, FIN = 2'd2} state_t;

  state_t        state;
  logic          lat_mode;
  logic [BW-1:0] lat_board;
  logic [3:0]    cx, cy;
  logic [2:0]    px, py;

  logic       last_px, last_py, last_cx, last_cy, cell_end, last_pix;
  logic [2:0] nx_px, nx_py;
  logic [3:0] nx_cx, nx_cy;
  logic       req_valid;
  logic [3:0] start_cx, start_cy;

  function automatic logic [7:0] calc_x(input logic [BW-1:0] b, input logic [3:0] c,
                                        input logic [2:0] p);
    int v;
    v = X_BASE + int'(b) * X_STRIDE + int'(c) * PITCH + int'(p);
    return v[7:0];
  endfunction

  function automatic logic [6:0] calc_y(input logic [3:0] c, input logic [2:0] p);
    int v;
    v = Y_BASE + int'(c) * PITCH + int'(p);
    return v[6:0];
  endfunction

  assign state_dbg = state;

  // Step order: px innermost, then py; in fill mode cells advance cx then cy.
  always_comb begin
    last_px  = (int'(px) == CELL - 1);
    last_py  = (int'(py) == CELL - 1);
    last_cx  = (int'(cx) == GRID - 1);
    last_cy  = (int'(cy) == GRID - 1);
    cell_end = last_px && last_py;
    last_pix = cell_end && (!lat_mode || (last_cx && last_cy));
    nx_px    = last_px ? 3'd0 : px + 3'd1;
    nx_py    = py;
    nx_cx    = cx;
    nx_cy    = cy;
    if (last_px) nx_py = last_py ? 3'd0 : py + 3'd1;
    if (lat_mode && cell_end) begin
      nx_cx = last_cx ? 4'd0 : cx + 4'd1;
      if (last_cx) nx_cy = cy + 4'd1;
    end
  end

  always_comb begin
    req_valid = (int'(bus.board) < NUM_BOARDS) &&
                (bus.mode || ((int'(bus.cellX) < GRID) && (int'(bus.cellY) < GRID)));
    start_cx  = bus.mode ? 4'd0 : bus.cellX;
    start_cy  = bus.mode ? 4'd0 : bus.cellY;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= IDLE;
      lat_mode      <= 1'b0;
      lat_board     <= '0;
      cx            <= '0;
      cy            <= '0;
      px            <= '0;
      py            <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.plotEn    <= 1'b0;
      bus.posX      <= '0;
      bus.posY      <= '0;
      bus.colourOut <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (req_valid) begin
              // First pixel is registered here so it appears the cycle after acceptance.
              state         <= DRAW;
              lat_mode      <= bus.mode;
              lat_board     <= bus.board;
              cx            <= start_cx;
              cy            <= start_cy;
              px            <= '0;
              py            <= '0;
              bus.busy      <= 1'b1;
              bus.plotEn    <= 1'b1;
              bus.posX      <= calc_x(bus.board, start_cx, 3'd0);
              bus.posY      <= calc_y(start_cy, 3'd0);
              bus.colourOut <= bus.colourIn;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        DRAW: begin
          if (last_pix) begin
            state      <= FIN;
            bus.busy   <= 1'b0;
            bus.plotEn <= 1'b0;
            bus.done   <= 1'b1;
          end else begin
            px       <= nx_px;
            py       <= nx_py;
            cx       <= nx_cx;
            cy       <= nx_cy;
            bus.posX <= calc_x(lat_board, nx_cx, nx_px);
            bus.posY <= calc_y(nx_cy, nx_py);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
